// File: rtl/imm_arb_pkg.sv
// Shared constants and helpers for the immediate sign-extension arbiter.
// Requester ids, priority mode encodings and the 12->32 sign extension.
package imm_arb_pkg;

  localparam int IMM_W = 12;
  localparam int XLEN  = 32;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_S = 1'b1;

  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_mode_e;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: single valid wins outright; contention resolved by
// fixed priority (requester 0) or by alternating against the last grant.
module rr_arb2
  import imm_arb_pkg::*;
#(
  parameter prio_mode_e MODE = PRIO_RR
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    // NOTE: gnt gets a default before the case so no path leaves it unassigned.
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (MODE == PRIO_FIXED || last_gnt == REQ_S) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Priority only rotates on a real transfer, never on idle cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: flop state always uses <= so every register samples pre-edge values.
      last_gnt <= REQ_S;
    end else if (accept) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Shares one 12->32 sign-extension path between I-type and S-type decode
// requesters, presenting results through a single registered output slot.
module imm_ext_arbiter
  import imm_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req0_valid_i,
  input  logic [IMM_W-1:0] req0_imm_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [IMM_W-1:0] req1_imm_i,
  output logic             req1_ready_o,
  output logic             out_valid_o,
  output logic [XLEN-1:0]  out_data_o,
  output logic             out_id_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] acc0_cnt_o,
  output logic [CNT_W-1:0] acc1_cnt_o
);

  localparam prio_mode_e ARB_MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

  logic [1:0]       gnt;
  logic             free;
  logic             accept;
  logic             acc_id;
  logic [IMM_W-1:0] acc_imm;

  // Slot can take a new result when empty or being drained this cycle.
  assign free         = !out_valid_o || out_ready_i;
  assign req0_ready_o = gnt[0] && req0_valid_i && free;
  assign req1_ready_o = gnt[1] && req1_valid_i && free;
  assign accept       = req0_ready_o || req1_ready_o;
  assign acc_id       = req1_ready_o ? REQ_S : REQ_I;
  assign acc_imm      = req1_ready_o ? req1_imm_i : req0_imm_i;

  rr_arb2 #(
    .MODE (ARB_MODE)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid   ({req1_valid_i, req0_valid_i}),
    .accept  (accept),
    .gnt     (gnt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= REQ_I;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_data_o  <= sext_imm(acc_imm);
      out_id_o    <= acc_id;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Counters wrap naturally; they move on the same edge as the slot load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc0_cnt_o <= '0;
      acc1_cnt_o <= '0;
    end else begin
      if (req0_ready_o) acc0_cnt_o <= acc0_cnt_o + CNT_W'(1);
      if (req1_ready_o) acc1_cnt_o <= acc1_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: a round-robin and a fixed-priority instance
// share stimulus and are each compared against a cycle-level reference model.
module tb_imm_ext_arbiter;

  logic        clk_i;
  logic        rst_n_i;
  logic        req0_valid;
  logic [11:0] req0_imm;
  logic        req1_valid;
  logic [11:0] req1_imm;
  logic        out_ready;

  logic [1:0]        r0, r1, ov, oid;
  logic [1:0][31:0]  od;
  logic [1:0][15:0]  c0, c1;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
  bit          m_ov   [2];
  bit [31:0]   m_od   [2];
  bit          m_id   [2];
  bit          m_last [2];
  int unsigned m_c0   [2];
  int unsigned m_c1   [2];
  bit          acc0   [2];
  bit          acc1   [2];

  imm_ext_arbiter #(.PRIO_MODE(0), .CNT_W(16)) dut_rr (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req0_valid_i (req0_valid),
    .req0_imm_i   (req0_imm),
    .req0_ready_o (r0[0]),
    .req1_valid_i (req1_valid),
    .req1_imm_i   (req1_imm),
    .req1_ready_o (r1[0]),
    .out_valid_o  (ov[0]),
    .out_data_o   (od[0]),
    .out_id_o     (oid[0]),
    .out_ready_i  (out_ready),
    .acc0_cnt_o   (c0[0]),
    .acc1_cnt_o   (c1[0])
  );

  imm_ext_arbiter #(.PRIO_MODE(1), .CNT_W(16)) dut_fx (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req0_valid_i (req0_valid),
    .req0_imm_i   (req0_imm),
    .req0_ready_o (r0[1]),
    .req1_valid_i (req1_valid),
    .req1_imm_i   (req1_imm),
    .req1_ready_o (r1[1]),
    .out_valid_o  (ov[1]),
    .out_data_o   (od[1]),
    .out_id_o     (oid[1]),
    .out_ready_i  (out_ready),
    .acc0_cnt_o   (c0[1]),
    .acc1_cnt_o   (c1[1])
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Two's complement value of a 12-bit field, widened to 32 bits.
  function automatic bit [31:0] model_sext(input int unsigned imm);
    int v;
    v = (imm >= 2048) ? int'(imm) - 4096 : int'(imm);
    return 32'(v);
  endfunction

  // Winner index from the arbitration rules, -1 when nobody is valid.
  function automatic int model_pick(input bit v0, input bit v1, input bit fixed, input bit last);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (fixed) return 0;
    return (last == 1'b1) ? 0 : 1;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ov[m]   = 1'b0;
      m_od[m]   = '0;
      m_id[m]   = 1'b0;
      m_last[m] = 1'b1;
      m_c0[m]   = 0;
      m_c1[m]   = 0;
      acc0[m]   = 1'b0;
      acc1[m]   = 1'b0;
    end
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int w;
    bit free;
    @(negedge clk_i);
    for (int m = 0; m < 2; m++) begin
      free    = !m_ov[m] || out_ready;
      w       = model_pick(req0_valid, req1_valid, m == 1, m_last[m]);
      acc0[m] = free && (w == 0);
      acc1[m] = free && (w == 1);
      check($sformatf("m%0d_rdy0", m), 32'(r0[m]), 32'(acc0[m]));
      check($sformatf("m%0d_rdy1", m), 32'(r1[m]), 32'(acc1[m]));
      check($sformatf("m%0d_valid", m), 32'(ov[m]), 32'(m_ov[m]));
      check($sformatf("m%0d_data", m), od[m], m_od[m]);
      check($sformatf("m%0d_id", m), 32'(oid[m]), 32'(m_id[m]));
      check($sformatf("m%0d_cnt0", m), 32'(c0[m]), m_c0[m] & 32'hFFFF);
      check($sformatf("m%0d_cnt1", m), 32'(c1[m]), m_c1[m] & 32'hFFFF);
    end
    @(posedge clk_i);
    for (int m = 0; m < 2; m++) begin
      if (acc0[m]) begin
        m_ov[m] = 1'b1; m_od[m] = model_sext(req0_imm); m_id[m] = 1'b0;
        m_last[m] = 1'b0; m_c0[m]++;
      end else if (acc1[m]) begin
        m_ov[m] = 1'b1; m_od[m] = model_sext(req1_imm); m_id[m] = 1'b1;
        m_last[m] = 1'b1; m_c1[m]++;
      end else if (out_ready) begin
        m_ov[m] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n_i = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s_m%0d_valid", tag, m), 32'(ov[m]), 32'h0);
      check($sformatf("%s_m%0d_data", tag, m), od[m], 32'h0);
      check($sformatf("%s_m%0d_id", tag, m), 32'(oid[m]), 32'h0);
      check($sformatf("%s_m%0d_cnt0", tag, m), 32'(c0[m]), 32'h0);
      check($sformatf("%s_m%0d_cnt1", tag, m), 32'(c1[m]), 32'h0);
    end
    model_reset();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    rst_n_i    = 1'b1;
    req0_valid = 1'b0;
    req0_imm   = '0;
    req1_valid = 1'b0;
    req1_imm   = '0;
    out_ready  = 1'b0;
    model_reset();
    #2;
    do_reset("rst0");

    // Single requester, positive boundary immediate, readiness is combinational.
    req0_valid = 1'b1; req0_imm = 12'h7FF; out_ready = 1'b1;
    #1;
    check("t1_rdy0_same_cycle", 32'(r0[0]), 32'h1);
    step();
    req0_valid = 1'b0;
    check("t1_data", od[0], 32'h0000_07FF);
    check("t1_id", 32'(oid[0]), 32'h0);
    check("t1_cnt0", 32'(c0[0]), 32'h1);

    // Contention from reset: round-robin alternates, fixed priority never serves req1.
    do_reset("rst1");
    req0_valid = 1'b1; req0_imm = 12'h800;
    req1_valid = 1'b1; req1_imm = 12'h001; out_ready = 1'b1;
    step();
    check("rr_out0_data", od[0], 32'hFFFF_F800);
    check("rr_out0_id", 32'(oid[0]), 32'h0);
    step();
    check("rr_out1_data", od[0], 32'h0000_0001);
    check("rr_out1_id", 32'(oid[0]), 32'h1);
    step();
    check("rr_out2_data", od[0], 32'hFFFF_F800);
    check("rr_out2_id", 32'(oid[0]), 32'h0);
    check("fx_id_always0", 32'(oid[1]), 32'h0);
    check("fx_cnt1_zero", 32'(c1[1]), 32'h0);
    check("fx_cnt0_three", 32'(c0[1]), 32'h3);

    // Back-pressure: full slot holds for three cycles, then req1 is taken.
    do_reset("rst2");
    req0_valid = 1'b1; req0_imm = 12'h123; req1_valid = 1'b0; out_ready = 1'b0;
    step();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_imm = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy0_low", 32'(r0[0]), 32'h0);
      check("bp_rdy1_low", 32'(r1[0]), 32'h0);
      step();
      check("bp_hold_data", od[0], 32'h0000_0123);
      check("bp_hold_valid", 32'(ov[0]), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy1_release", 32'(r1[0]), 32'h1);
    step();
    req1_valid = 1'b0;
    check("bp_data", od[0], 32'hFFFF_FFFF);
    check("bp_id", 32'(oid[0]), 32'h1);

    // Counter wrap after 65536 accepts.
    do_reset("rst3");
    req0_valid = 1'b1; req0_imm = 12'h00A; out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    check("wrap_cnt0_max", 32'(c0[0]), 32'h0000_FFFF);
    step();
    check("wrap_cnt0_zero", 32'(c0[0]), 32'h0);
    check("wrap_fx_cnt0_zero", 32'(c0[1]), 32'h0);
    req0_valid = 1'b0;

    // Randomized traffic; a requester holds its request until someone takes it.
    do_reset("rst4");
    for (int i = 0; i < 1500; i++) begin
      if (!req0_valid || acc0[0] || acc0[1]) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_imm   = 12'($urandom);
      end
      if (!req1_valid || acc1[0] || acc1[1]) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_imm   = 12'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Reset mid-stream with a full slot, then contention must grant req0.
    req0_valid = 1'b1; req0_imm = 12'h456; req1_valid = 1'b0; out_ready = 1'b0;
    step();
    check("mid_slot_full", 32'(ov[0]), 32'h1);
    #2;
    do_reset("mid_rst");
    req0_valid = 1'b1; req1_valid = 1'b1; req1_imm = 12'h321; out_ready = 1'b1;
    #1;
    check("post_rst_rr_rdy0", 32'(r0[0]), 32'h1);
    check("post_rst_rr_rdy1", 32'(r1[0]), 32'h0);
    check("post_rst_fx_rdy0", 32'(r0[1]), 32'h1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
